capture_ctrl: RTL
=================

// Module: capture_ctrl
// PURPOSE
//  Trigger/capture sequencer for the scope sample buffer. Sits between adc_com's sample stream and
//  the 2^ADDR_W x DATA_W capture RAM, and drives the RAM write port as a circular buffer. Holds
//  PRETRIG samples of history, waits for a slope/level trigger, fills the post-trigger part, then
//  freezes the buffer for Pi readout until the Pi signals graph done.
// PARAMETERS
//  ADDR_W        12    buffer address width; DEPTH = 2**ADDR_W samples
//  DATA_W        8     sample width
//  PRETRIG       1024  samples kept before trigger sample; legal 1..DEPTH-1
//  AUTO_TIMEOUT  4096  ARMED samples before forced trigger (only with CAPTURE_AUTO_TRIG_EN)
// PORTS
//  osc_clk       in   1       system clock; all logic on rising edge
//  reset_n       in   1       synchronous, active-low reset
//  run           in   1       level; 1 = acquisition enabled
//  single        in   1       level; 1 = stop in IDLE after one capture is released
//  trig_level    in   DATA_W  unsigned trigger threshold
//  trig_rising   in   1       1 = rising-slope trigger, 0 = falling-slope trigger
//  sample_valid  in   1       one-cycle strobe, new sample on sample_data
//  sample_data   in   DATA_W  unsigned ADC sample
//  graph_done    in   1       one-cycle pulse from Pi side: buffer consumed
//  wr_en         out  1       RAM write strobe
//  wr_adr        out  ADDR_W  RAM write address
//  wr_data       out  DATA_W  RAM write data
//  trig_adr      out  ADDR_W  address of trigger sample in the frozen buffer
//  buf_ready     out  1       1 = buffer frozen, readout allowed
//  auto_trig     out  1       1 = current frozen capture was force-triggered
// BEHAVIOUR
//  - Reset (reset_n=0 at a clock edge, any state incl. mid-capture): state=IDLE; wr_en, wr_adr,
//    wr_data, trig_adr, buf_ready, auto_trig, prev-sample and all counters = 0.
//  - Accepted sample = sample_valid=1 in FILL, ARMED or POST. Each accepted sample: next cycle
//    wr_en=1, wr_data=sample, wr_adr=write pointer; pointer then +1 mod DEPTH (wraps DEPTH-1 -> 0).
//    Latency sample_valid -> wr_en = 1 cycle. wr_en never 1 in IDLE or READY.
//  - prev = last accepted sample; updated on every accepted sample.
//  - States:
//    IDLE : run=1 -> FILL (pre_cnt=0). Pointer retained, not cleared.
//    FILL : count accepted samples; the PRETRIG-th accepted sample -> ARMED. No trigger checks.
//    ARMED: per accepted sample s: rising hit = prev<trig_level && s>=trig_level; falling hit =
//           prev>trig_level && s<=trig_level. Hit -> s written, trig_adr=its address,
//           post_cnt=0 -> POST.
//    POST : after DEPTH-PRETRIG-1 more accepted samples -> READY. Buffer then holds exactly
//           PRETRIG pre-trigger, 1 trigger, DEPTH-PRETRIG-1 post samples; oldest at final pointer.
//    READY: buf_ready=1 from the cycle after the last write. graph_done -> buf_ready=0,
//           auto_trig=0; next state IDLE if single=1 or run=0, else FILL.
//  - run=0 in FILL/ARMED -> IDLE next cycle, capture abandoned; a sample accepted that same cycle
//    is still written. run ignored in POST/READY (capture completes).
//  - graph_done outside READY ignored. trig_level/trig_rising sampled live each accepted sample.
//  - Comparisons unsigned, DATA_W wide; counters sized ADDR_W+1, no overflow.
// CONFIGURATION
//  CAPTURE_AUTO_TRIG_EN defined: ARMED counts accepted samples from entry; if the AUTO_TIMEOUT-th
//    has no hit, it is treated as the trigger sample; auto_trig=1 with buf_ready, cleared on
//    graph_done. A real hit on that same sample wins (auto_trig=0).
//  Not defined: no timeout counter; ARMED waits indefinitely; auto_trig tied to 0.
// TESTING  (ADDR_W=4, PRETRIG=4, AUTO_TIMEOUT=8, trig_level=35)
//  1 rising ramp 0,10,20,...,150, run=1 -> trigger on 40, trig_adr=4, 16 writes adr 0..15,
//    buf_ready=1 one cycle after adr 15 write, pointer=0.
//  2 samples 0,50,0,0 (in FILL) then 0,0,50 -> no trigger in FILL; trigger on 2nd 50, trig_adr=6.
//  3 trig_rising=0, samples 60,60,60,60,40,30 -> trigger on 30 (40>35), trig_adr=5.
//  4 single=0, graph_done in READY -> buf_ready=0 next cycle, FILL resumes at adr 0;
//    single=1 -> IDLE, wr_en stays 0 with sample_valid toggling; graph_done in ARMED ignored.
//  5 reset_n=0 for 1 cycle during POST -> all outputs 0 next cycle, IDLE; run=0 in ARMED -> IDLE.
//  6 CAPTURE_AUTO_TRIG_EN, constant 0 -> forced trigger on 8th ARMED sample, trig_adr=11,
//    auto_trig=1 with buf_ready; macro undefined -> ARMED indefinitely, auto_trig=0.

Source files
------------

// File: rtl/capture_ctrl.sv
// capture_ctrl -- trigger/capture sequencer for the scope sample buffer.
//
// Sits between the ADC sample stream and a 2**ADDR_W x DATA_W capture RAM. The
// RAM is written as a circular buffer. The block keeps PRETRIG samples of
// history and waits for a slope/level trigger. It then fills the post-trigger
// part and freezes the buffer for readout until graph_done is pulsed.
//
// Optional feature macro: CAPTURE_AUTO_TRIG_EN
//   defined   : ARMED forces a trigger on its AUTO_TIMEOUT-th accepted sample
//               and flags the capture through auto_trig.
//   undefined : ARMED waits indefinitely and auto_trig is tied low.
//
// Ports
//   osc_clk      in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   run          in   acquisition enable (level)
//   single       in   stop in IDLE after one capture is released (level)
//   trig_level   in   unsigned trigger threshold
//   trig_rising  in   1 = rising-slope trigger, 0 = falling-slope trigger
//   sample_valid in   one-cycle strobe qualifying sample_data
//   sample_data  in   unsigned ADC sample
//   graph_done   in   one-cycle pulse: frozen buffer has been consumed
//   wr_en        out  RAM write strobe
//   wr_adr       out  RAM write address
//   wr_data      out  RAM write data
//   trig_adr     out  address of the trigger sample in the frozen buffer
//   buf_ready    out  buffer frozen, readout allowed
//   auto_trig    out  frozen capture was force-triggered
module capture_ctrl #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 8,
   parameter int PRETRIG      = 1024,
   parameter int AUTO_TIMEOUT = 4096
) (
   input  logic              osc_clk,
   input  logic              reset_n,
   input  logic              run,
   input  logic              single,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_rising,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              graph_done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_adr,
   output logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] trig_adr,
   output logic              buf_ready,
   output logic              auto_trig
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CW    = ADDR_W + 1;
   localparam logic [CW-1:0] PRE_N  = CW'(PRETRIG);
   localparam logic [CW-1:0] POST_N = CW'(DEPTH - PRETRIG - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      ARMED = 3'd2,
      POST  = 3'd3,
      READY = 3'd4
   } state_t;

   state_t state, next_state;

   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] prev;
   logic [CW-1:0]     pre_cnt;
   logic [CW-1:0]     post_cnt;
   logic              hold;      // single capture released; wait for run or single to drop
   logic              accept;
   logic              hit;
   logic              timeout;
   logic              trig_now;

   // Unsigned slope/level detector between the previous and current sample.
   function automatic logic slope_hit(input logic [DATA_W-1:0] p,
                                      input logic [DATA_W-1:0] s,
                                      input logic [DATA_W-1:0] lvl,
                                      input logic              rising);
      if (rising)
         return (p < lvl) && (s >= lvl);
      else
         return (p > lvl) && (s <= lvl);
   endfunction

   always_comb begin
      accept     = sample_valid && (state == FILL || state == ARMED || state == POST);
      hit        = slope_hit(prev, sample_data, trig_level, trig_rising);
      // run=0 in ARMED abandons the capture, so it also suppresses a trigger
      trig_now   = accept && run && (state == ARMED) && (hit || timeout);
      next_state = state;
      case (state)
         IDLE:  if (run && !hold) next_state = FILL;
         FILL: begin
            if (!run)
               next_state = IDLE;
            else if (accept && (pre_cnt + 1'b1 == PRE_N))
               next_state = ARMED;
         end
         ARMED: begin
            if (!run)
               next_state = IDLE;
            else if (trig_now)
               next_state = (POST_N == '0) ? READY : POST;
         end
         POST:  if (accept && (post_cnt + 1'b1 == POST_N)) next_state = READY;
         READY: if (graph_done) next_state = (single || !run) ? IDLE : FILL;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge osc_clk) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // write port, pointer, history and counters
   always_ff @(posedge osc_clk) begin
      if (!reset_n) begin
         wr_en     <= 1'b0;
         wr_adr    <= '0;
         wr_data   <= '0;
         trig_adr  <= '0;
         buf_ready <= 1'b0;
         ptr       <= '0;
         prev      <= '0;
         pre_cnt   <= '0;
         post_cnt  <= '0;
         hold      <= 1'b0;
      end else begin
         wr_en <= accept;
         if (accept) begin
            wr_adr  <= ptr;
            wr_data <= sample_data;
            ptr     <= ptr + 1'b1;
            prev    <= sample_data;
         end

         if (state != FILL)
            pre_cnt <= '0;
         else if (accept)
            pre_cnt <= pre_cnt + 1'b1;

         if (state != POST)
            post_cnt <= '0;
         else if (accept)
            post_cnt <= post_cnt + 1'b1;

         if (trig_now)
            trig_adr <= ptr;

         // rises the cycle after the final write, drops on graph_done
         if (state == READY)
            buf_ready <= !graph_done;
         else
            buf_ready <= 1'b0;

         if (!run || !single)
            hold <= 1'b0;
         else if (state == READY && graph_done)
            hold <= 1'b1;
      end
   end

`ifdef CAPTURE_AUTO_TRIG_EN
   localparam logic [CW-1:0] AUTO_N = CW'(AUTO_TIMEOUT);

   logic [CW-1:0] to_cnt;
   logic          forced;
   logic          auto_q;

   assign timeout = (to_cnt + 1'b1 == AUTO_N);

   always_ff @(posedge osc_clk) begin
      if (!reset_n) begin
         to_cnt <= '0;
         forced <= 1'b0;
         auto_q <= 1'b0;
      end else begin
         if (state != ARMED)
            to_cnt <= '0;
         else if (accept)
            to_cnt <= to_cnt + 1'b1;

         // a real hit on the timeout sample counts as a normal trigger
         if (trig_now)
            forced <= !hit;

         if (state == READY)
            auto_q <= graph_done ? 1'b0 : forced;
         else
            auto_q <= 1'b0;
      end
   end

   assign auto_trig = auto_q;
`else
   assign timeout   = 1'b0;
   assign auto_trig = 1'b0;
`endif

endmodule
